// File: rtl/rvfi_arb_pkg.sv
// rvfi_arb_pkg: shared retirement packet type and widths for the RVFI retire arbiter
package rvfi_arb_pkg;
  localparam int XLEN = 32;
  localparam int ORDER_W = 64;
  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic               trap;
  } retire_pkt_t;
  function automatic int pkt_width();
    return $bits(retire_pkt_t);
  endfunction
endpackage

// File: rtl/rvfi_retire_arbiter_if.sv
// rvfi_retire_arbiter_if: parallel retirement lanes in, one ordered retirement stream and error flags out
interface rvfi_retire_arbiter_if #(
  parameter int NRET = 2,
  parameter int XLEN = 32
);
  logic [NRET-1:0]      in_valid;
  logic [NRET*64-1:0]   in_order;
  logic [NRET*32-1:0]   in_insn;
  logic [NRET*XLEN-1:0] in_pc_rdata;
  logic [NRET*XLEN-1:0] in_pc_wdata;
  logic [NRET-1:0]      in_trap;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_order;
  logic [31:0]          out_insn;
  logic [XLEN-1:0]      out_pc_rdata;
  logic [XLEN-1:0]      out_pc_wdata;
  logic                 out_trap;
  logic                 err_overflow;
  logic                 err_order;
  logic                 err_stall;
  modport master (
    input  in_valid, in_order, in_insn, in_pc_rdata, in_pc_wdata, in_trap, out_ready,
    output out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata, out_trap,
    output err_overflow, err_order, err_stall
  );
  modport slave (
    output in_valid, in_order, in_insn, in_pc_rdata, in_pc_wdata, in_trap, out_ready,
    input  out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata, out_trap,
    input  err_overflow, err_order, err_stall
  );
endinterface

// File: rtl/rvfi_retire_fifo.sv
// rvfi_retire_fifo: per-lane packet FIFO; a push into a full FIFO is accepted only when the head pops on the same edge
module rvfi_retire_fifo
  import rvfi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  retire_pkt_t wdata,
  output logic        full,
  output logic        empty,
  output retire_pkt_t head
);
  localparam int AW = $clog2(DEPTH);
  retire_pkt_t   mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];
  // pointer and occupancy update; reset discards buffered packets and refuses the push on that edge
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + AW'(do_pop);
      wptr  <= wptr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // packet storage; when full the write lands in the slot the head vacates
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/rvfi_retire_arbiter.sv
// rvfi_retire_arbiter: merges NRET RVFI retirement lanes into one stream ordered by rvfi_order
module rvfi_retire_arbiter #(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic                  clock,
  input logic                  resetn,
  rvfi_retire_arbiter_if.master bus
);
  import rvfi_arb_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = NRET > 1 ? $clog2(NRET) : 1;
  retire_pkt_t        wdata [NRET];
  retire_pkt_t        head  [NRET];
  logic [NRET-1:0]    full;
  logic [NRET-1:0]    empty;
  logic [NRET-1:0]    match;
  logic [NRET-1:0]    stale;
  logic [NRET-1:0]    pop;
  logic [SW-1:0]      sel;
  logic               dup;
  logic               fire;
  logic [ORDER_W-1:0] exp_order;
  logic [CW-1:0]      stall_cnt;
  logic [CW-1:0]      stall_next;
  logic               ovf_q;
  logic               ord_q;
  logic               stall_q;
  genvar i;
  for (i = 0; i < NRET; i++) begin : g_lane
    assign wdata[i] = '{
      order:    bus.in_order[64*i +: 64],
      insn:     bus.in_insn[32*i +: 32],
      pc_rdata: bus.in_pc_rdata[XLEN*i +: XLEN],
      pc_wdata: bus.in_pc_wdata[XLEN*i +: XLEN],
      trap:     bus.in_trap[i]
    };
    assign match[i] = !empty[i] && head[i].order == exp_order;
    assign stale[i] = !empty[i] && head[i].order < exp_order;
    assign pop[i]   = stale[i] || (fire && sel == SW'(i));
    rvfi_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (bus.in_valid[i]),
      .pop    (pop[i]),
      .wdata  (wdata[i]),
      .full   (full[i]),
      .empty  (empty[i]),
      .head   (head[i])
    );
  end
  // lowest matching lane wins; more than one match means a duplicated order
  always_comb begin
    sel = '0;
    for (int k = NRET - 1; k >= 0; k--) sel = match[k] ? SW'(k) : sel;
    dup = $countones(match) > 1;
  end
  // stall counter runs while anything is buffered and nothing leaves, saturating at TIMEOUT
  always_comb begin
    stall_next = (&empty || fire) ? '0 : (stall_cnt == CW'(TIMEOUT) ? stall_cnt : stall_cnt + CW'(1));
  end
  assign fire             = bus.out_valid && bus.out_ready;
  assign bus.out_valid    = |match;
  assign bus.out_order    = head[sel].order;
  assign bus.out_insn     = head[sel].insn;
  assign bus.out_pc_rdata = head[sel].pc_rdata;
  assign bus.out_pc_wdata = head[sel].pc_wdata;
  assign bus.out_trap     = head[sel].trap;
  assign bus.err_overflow = ovf_q;
  assign bus.err_order    = ord_q;
  assign bus.err_stall    = stall_q;
  // expected order, stall count and sticky error flags
  always_ff @(posedge clock) begin
    if (!resetn) begin
      exp_order <= '0;
      stall_cnt <= '0;
      ovf_q     <= 1'b0;
      ord_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      exp_order <= fire ? exp_order + 64'd1 : exp_order;
      stall_cnt <= stall_next;
      ovf_q     <= ovf_q | (|(bus.in_valid & full & ~pop));
      ord_q     <= ord_q | (|stale) | dup;
      stall_q   <= stall_q | (stall_next == CW'(TIMEOUT));
    end
  end
endmodule
